eth_reg_arbiter: RTL

- Shares the single Avalon-MM register port of the Ethernet MAC IP between two requesters.
  - Port 0: the boot-time configuration sequencer (high priority).
  - Port 1: a runtime requester, e.g. the statistics/status poller driven from the switches/hex display logic.
- Serialises one read or write at a time and honours the MAC's busy (waitrequest) signal.
- Aborts any transaction stalled beyond a timeout.
- Sits between the requesters and the MAC's reg_* pins, in the clk_hifreq domain.

---
 rtl/eth_pkg.sv | 19 +
 rtl/eth_reg_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/eth_pkg.sv
// Shared types and widths for the Ethernet MAC register-port arbiter.
package eth_pkg;

    localparam int ETH_REG_ADDR_W = 8;
    localparam int ETH_REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      wr;
        logic [ETH_REG_ADDR_W-1:0] addr;
        logic [ETH_REG_DATA_W-1:0] wdata;
    } reg_cmd_t;

endpackage

// File: rtl/eth_reg_arbiter.sv
// Two-port arbiter for the MAC Avalon-MM register port: port 0 has priority,
// port 1 is guaranteed a slot after MAX_CONSEC contested port-0 grants.
module eth_reg_arbiter
    import eth_pkg::*;
#(
    parameter int ADDR_W     = ETH_REG_ADDR_W,
    parameter int DATA_W     = ETH_REG_DATA_W,
    parameter int TIMEOUT    = 255,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk_hifreq,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data_in,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_data_out,
    input  logic              reg_busy
);

    localparam logic [15:0] TMO_L  = 16'(TIMEOUT);
    localparam logic [7:0]  MAXC_L = 8'(MAX_CONSEC);

    state_t            r_state,  w_state_next;
    reg_cmd_t          r_cmd,    w_cmd_next;
    logic              r_grant1, w_grant1_next;
    logic [7:0]        r_consec, w_consec_next;
    logic [15:0]       r_tmo,    w_tmo_next;
    logic              r_reg_wr, w_reg_wr_next;
    logic              r_reg_rd, w_reg_rd_next;
    logic              r_done0,  w_done0_next;
    logic              r_done1,  w_done1_next;
    logic [DATA_W-1:0] r_rdata,  w_rdata_next;
    logic              r_err,    w_err_next;
    logic              w_pick1;
    logic [15:0]       w_tmo_inc;

    assign w_pick1   = req1 && (!req0 || (r_consec == MAXC_L));
    assign w_tmo_inc = r_tmo + 16'd1;

    always_comb begin
        w_state_next  = r_state;
        w_cmd_next    = r_cmd;
        w_grant1_next = r_grant1;
        w_consec_next = r_consec;
        w_tmo_next    = r_tmo;
        w_reg_wr_next = r_reg_wr;
        w_reg_rd_next = r_reg_rd;
        w_done0_next  = 1'b0;
        w_done1_next  = 1'b0;
        w_rdata_next  = r_rdata;
        w_err_next    = r_err;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant1_next = w_pick1;
                    if (w_pick1) begin
                        w_cmd_next.wr    = wr1;
                        w_cmd_next.addr  = ETH_REG_ADDR_W'(addr1);
                        w_cmd_next.wdata = ETH_REG_DATA_W'(wdata1);
                        w_consec_next    = 8'd0;
                    end else begin
                        w_cmd_next.wr    = wr0;
                        w_cmd_next.addr  = ETH_REG_ADDR_W'(addr0);
                        w_cmd_next.wdata = ETH_REG_DATA_W'(wdata0);
                        // Count only grants that actually made port 1 wait.
                        if (!req1)
                            w_consec_next = 8'd0;
                        else if (r_consec != MAXC_L)
                            w_consec_next = r_consec + 8'd1;
                    end
                    w_reg_wr_next = w_pick1 ? wr1 : wr0;
                    w_reg_rd_next = w_pick1 ? !wr1 : !wr0;
                    w_state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (!reg_busy) begin
                    if (r_reg_rd)
                        w_rdata_next = reg_data_out;
                    w_err_next    = 1'b0;
                    w_reg_wr_next = 1'b0;
                    w_reg_rd_next = 1'b0;
                    w_done0_next  = !r_grant1;
                    w_done1_next  = r_grant1;
                    w_state_next  = DONE;
                end else begin
                    w_tmo_next = w_tmo_inc;
                    if (w_tmo_inc == TMO_L) begin
                        w_err_next    = 1'b1;
                        w_reg_wr_next = 1'b0;
                        w_reg_rd_next = 1'b0;
                        w_done0_next  = !r_grant1;
                        w_done1_next  = r_grant1;
                        w_state_next  = DONE;
                    end
                end
            end
            DONE: begin
                w_tmo_next   = 16'd0;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_hifreq) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cmd    <= '0;
            r_grant1 <= 1'b0;
            r_consec <= 8'd0;
            r_tmo    <= 16'd0;
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cmd    <= w_cmd_next;
            r_grant1 <= w_grant1_next;
            r_consec <= w_consec_next;
            r_tmo    <= w_tmo_next;
            r_reg_wr <= w_reg_wr_next;
            r_reg_rd <= w_reg_rd_next;
            r_done0  <= w_done0_next;
            r_done1  <= w_done1_next;
            r_rdata  <= w_rdata_next;
            r_err    <= w_err_next;
        end
    end

    assign reg_addr    = ADDR_W'(r_cmd.addr);
    assign reg_data_in = DATA_W'(r_cmd.wdata);
    assign reg_wr      = r_reg_wr;
    assign reg_rd      = r_reg_rd;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign rdata       = r_rdata;
    assign err         = r_err;

endmodule
